// File: rtl/dram_pkg.sv
// Shared definitions for the single-bank SDRAM command interface.
// Holds command codes ({ras_n, cas_n, we_n}), the responder FSM state
// encoding and the bit positions inside the sticky err vector.
// Used by the device responder and by the controller-side bench.
package dram_pkg;

    // Command codes as seen on {ras_n, cas_n, we_n} while cs_n is low
    localparam logic [2:0] CMD_ACT  = 3'b011;
    localparam logic [2:0] CMD_PRE  = 3'b010;
    localparam logic [2:0] CMD_RD   = 3'b101;
    localparam logic [2:0] CMD_WR   = 3'b100;
    localparam logic [2:0] CMD_REF  = 3'b001;
    localparam logic [2:0] CMD_NOP  = 3'b111;
    localparam logic [2:0] CMD_BAD0 = 3'b000;
    localparam logic [2:0] CMD_BAD1 = 3'b110;

    // Responder bank state
    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_ACTIVATING  = 3'd1,
        ST_ROW_OPEN    = 3'd2,
        ST_PRECHARGING = 3'd3,
        ST_REFRESHING  = 3'd4
    } dram_state_e;

    // Sticky violation flag positions
    localparam int ERR_RW_CLOSED = 0;  // RD/WR with no open row
    localparam int ERR_ACT_BUSY  = 1;  // command while activating
    localparam int ERR_PRE_BUSY  = 2;  // command while precharging/refreshing
    localparam int ERR_ROW_OPEN  = 3;  // ACT/REF with a row already open
    localparam int ERR_REF_LATE  = 4;  // refresh interval exceeded
    localparam int ERR_BAD_CMD   = 5;  // unsupported code
    localparam int ERR_W         = 6;

    // True for the two codes the device does not implement
    function automatic logic cmd_is_unsupported(input logic [2:0] code);
        return (code == CMD_BAD0) || (code == CMD_BAD1);
    endfunction

    // True for column accesses
    function automatic logic cmd_is_access(input logic [2:0] code);
        return (code == CMD_RD) || (code == CMD_WR);
    endfunction

endpackage

// File: rtl/dram_rd_pipe.sv
// CAS-latency read pipeline. A word pushed on cycle N appears on dq_out
// with dq_oe high at N+CAS_LATENCY for one cycle. Each data stage only
// loads when a valid word arrives, so the last stage doubles as the
// "hold until next read" output register.
// Ports:
//   clk, reset          clock, synchronous active-high reset (flushes)
//   push_i, data_i      accepted read and the array word it fetched
//   dq_out_o, dq_oe_o   registered read data and bus-drive strobe
module dram_rd_pipe #(
    parameter int DATA_WIDTH  = 32,
    parameter int CAS_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0] dq_out_o,
    output logic                  dq_oe_o
);

    logic [CAS_LATENCY-1:0] vld_q;
    logic [DATA_WIDTH-1:0]  dat_q [CAS_LATENCY];

    // Shift valid bits every cycle; advance data only behind a valid bit
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < CAS_LATENCY; i++) begin
                vld_q[i] <= 1'b0;
                dat_q[i] <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            vld_q[0] <= push_i;
            if (push_i) begin
                dat_q[0] <= data_i;
            end
            for (int i = 1; i < CAS_LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) begin
                    dat_q[i] <= dat_q[i-1];
                end
            end
        end
    end

    assign dq_oe_o  = vld_q[CAS_LATENCY-1];
    assign dq_out_o = dat_q[CAS_LATENCY-1];

endmodule

// File: rtl/dram_device_responder.sv
// Device-side responder for a single-bank SDRAM command bus.
// Decodes edge-accepted commands, tracks ACT/PRE/REF timing, serves
// RD/WR from an internal array and raises sticky protocol flags.
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   cs_n, ras_n, cas_n, we_n      command strobes
//   row_addr, col_addr, dq_in     address and write data
//   dq_out, dq_oe                 read data (held) and drive strobe
//   row_open, open_row            open-row flag and latched row
//   err                           sticky violation flags (dram_pkg ERR_*)
module dram_device_responder
    import dram_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ROW_WIDTH      = 13,
    parameter int COL_WIDTH      = 10,
    parameter int MEM_ADDR_WIDTH = 10,
    parameter int CAS_LATENCY    = 2,
    parameter int TRCD           = 2,
    parameter int TRP            = 2,
    parameter int TRFC           = 2,
    parameter int TREF_MAX       = 128
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cs_n,
    input  logic                  ras_n,
    input  logic                  cas_n,
    input  logic                  we_n,
    input  logic [ROW_WIDTH-1:0]  row_addr,
    input  logic [COL_WIDTH-1:0]  col_addr,
    input  logic [DATA_WIDTH-1:0] dq_in,
    output logic [DATA_WIDTH-1:0] dq_out,
    output logic                  dq_oe,
    output logic                  row_open,
    output logic [ROW_WIDTH-1:0]  open_row,
    output logic [ERR_W-1:0]      err
);

    localparam int TIM_W = 16;
    localparam int REF_W = $clog2(TREF_MAX + 1);
    localparam int ADDR_W = ROW_WIDTH + COL_WIDTH;
    localparam logic [REF_W-1:0] REF_MAX_C = REF_W'(TREF_MAX);

    dram_state_e            state_q, state_d;
    logic [TIM_W-1:0]       tim_q, tim_d;
    logic [REF_W-1:0]       ref_cnt_q, ref_cnt_d;
    logic [2:0]             prev_code_q;
    logic                   row_open_q, row_open_d;
    logic [ROW_WIDTH-1:0]   open_row_q, open_row_d;
    logic [ERR_W-1:0]       err_q, err_d;
    logic [DATA_WIDTH-1:0]  mem_q [2**MEM_ADDR_WIDTH];

    logic [2:0]                cmd_s;
    logic                      accept_s;
    logic                      wr_en_s;
    logic                      rd_push_s;
    logic [ADDR_W-1:0]         full_addr_s;
    logic [MEM_ADDR_WIDTH-1:0] mem_idx_s;
    logic                      unused_addr_s;

    // cs_n high reads as NOP; a command fires only on a change of code
    assign cmd_s    = cs_n ? CMD_NOP : {ras_n, cas_n, we_n};
    assign accept_s = (cmd_s != CMD_NOP) && (cmd_s != prev_code_q);

    assign full_addr_s   = {open_row_q, col_addr};
    assign mem_idx_s     = full_addr_s[MEM_ADDR_WIDTH-1:0];
    assign unused_addr_s = ^full_addr_s[ADDR_W-1:MEM_ADDR_WIDTH];

    // Command decode, bank FSM, timing countdown and sticky flags
    always_comb begin
        state_d    = state_q;
        tim_d      = tim_q;
        row_open_d = row_open_q;
        open_row_d = open_row_q;
        err_d      = err_q;
        wr_en_s    = 1'b0;
        rd_push_s  = 1'b0;

        if (ref_cnt_q == REF_MAX_C) begin
            ref_cnt_d = ref_cnt_q;
        end else begin
            ref_cnt_d = ref_cnt_q + REF_W'(1);
        end
        err_d[ERR_REF_LATE] = err_q[ERR_REF_LATE] | (ref_cnt_q == REF_MAX_C);
        err_d[ERR_BAD_CMD]  = err_q[ERR_BAD_CMD] | (accept_s & cmd_is_unsupported(cmd_s));

        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    case (cmd_s)
                        CMD_ACT: begin
                            state_d    = (TRCD == 1) ? ST_ROW_OPEN : ST_ACTIVATING;
                            tim_d      = TIM_W'(TRCD - 1);
                            row_open_d = 1'b1;
                            open_row_d = row_addr;
                        end
                        CMD_REF: begin
                            state_d   = (TRFC == 1) ? ST_IDLE : ST_REFRESHING;
                            tim_d     = TIM_W'(TRFC - 1);
                            ref_cnt_d = {REF_W{1'b0}};
                        end
                        CMD_RD, CMD_WR: begin
                            err_d[ERR_RW_CLOSED] = 1'b1;
                        end
                        default: begin
                            state_d = ST_IDLE;
                        end
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACTIVATING: begin
                err_d[ERR_ACT_BUSY] = err_q[ERR_ACT_BUSY] | accept_s;
                // Leave on the last counted cycle so ROW_OPEN lands at N+TRCD
                if (tim_q <= TIM_W'(1)) begin
                    state_d = ST_ROW_OPEN;
                    tim_d   = {TIM_W{1'b0}};
                end else begin
                    tim_d = tim_q - TIM_W'(1);
                end
            end
            ST_ROW_OPEN: begin
                if (accept_s) begin
                    case (cmd_s)
                        CMD_RD:  rd_push_s = 1'b1;
                        CMD_WR:  wr_en_s   = 1'b1;
                        CMD_PRE: begin
                            state_d    = (TRP == 1) ? ST_IDLE : ST_PRECHARGING;
                            tim_d      = TIM_W'(TRP - 1);
                            row_open_d = 1'b0;
                        end
                        CMD_ACT, CMD_REF: begin
                            err_d[ERR_ROW_OPEN] = 1'b1;
                        end
                        default: begin
                            state_d = ST_ROW_OPEN;
                        end
                    endcase
                end else begin
                    state_d = ST_ROW_OPEN;
                end
            end
            ST_PRECHARGING, ST_REFRESHING: begin
                err_d[ERR_PRE_BUSY]  = err_q[ERR_PRE_BUSY] | accept_s;
                err_d[ERR_RW_CLOSED] = err_q[ERR_RW_CLOSED] | (accept_s & cmd_is_access(cmd_s));
                if (tim_q <= TIM_W'(1)) begin
                    state_d = ST_IDLE;
                    tim_d   = {TIM_W{1'b0}};
                end else begin
                    tim_d = tim_q - TIM_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                tim_d   = {TIM_W{1'b0}};
            end
        endcase
    end

    // Control state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            tim_q       <= {TIM_W{1'b0}};
            ref_cnt_q   <= {REF_W{1'b0}};
            prev_code_q <= CMD_NOP;
            row_open_q  <= 1'b0;
            open_row_q  <= {ROW_WIDTH{1'b0}};
            err_q       <= {ERR_W{1'b0}};
        end else begin
            state_q     <= state_d;
            tim_q       <= tim_d;
            ref_cnt_q   <= ref_cnt_d;
            prev_code_q <= cmd_s;
            row_open_q  <= row_open_d;
            open_row_q  <= open_row_d;
            err_q       <= err_d;
        end
    end

    // Storage array; intentionally not reset
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[mem_idx_s] <= dq_in;
        end
    end

    // Asynchronous array read so a write on the previous edge is visible
    dram_rd_pipe #(
        .DATA_WIDTH  (DATA_WIDTH),
        .CAS_LATENCY (CAS_LATENCY)
    ) u_rd_pipe (
        .clk      (clk),
        .reset    (reset),
        .push_i   (rd_push_s),
        .data_i   (mem_q[mem_idx_s]),
        .dq_out_o (dq_out),
        .dq_oe_o  (dq_oe)
    );

    assign row_open = row_open_q;
    assign open_row = open_row_q;
    assign err      = err_q;

endmodule
